// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage data-bus access and MEM/WB pipeline register
// Ports: clk/rst (async, active-high); MEM_* bundle in; dbus_* req/ack data bus;
// stall to upstream; WB_* registered bundle out; misalign/bus_err one-cycle pulses.
module mem_wb_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_RegWrite,
  input  logic        MEM_mem_to_reg,
  input  logic        MEM_memwrite,
  input  logic [31:0] MEM_B,
  input  logic [31:0] MEM_C,
  input  logic [4:0]  MEM_writereg_num,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        stall,
  output logic        WB_RegWrite,
  output logic        WB_mem_to_reg,
  output logic [31:0] WB_C,
  output logic [31:0] WB_D,
  output logic [4:0]  WB_writereg_num,
  output logic        misalign,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic        abort;
  logic [31:0] rdata_q;
  logic        access, go;
  assign access = MEM_mem_to_reg | MEM_memwrite;
  assign go     = (state == IDLE) & access & (MEM_C[1:0] == 2'b00);
  // gated by rst so the freeze releases the instant reset is applied
  assign stall  = ~rst & (go | (state == WAIT));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      abort           <= 1'b0;
      rdata_q         <= '0;
      dbus_req        <= 1'b0;
      dbus_we         <= 1'b0;
      dbus_addr       <= '0;
      dbus_wdata      <= '0;
      WB_RegWrite     <= 1'b0;
      WB_mem_to_reg   <= 1'b0;
      WB_C            <= '0;
      WB_D            <= '0;
      WB_writereg_num <= '0;
      misalign        <= 1'b0;
      bus_err         <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: if (go) begin
          state       <= WAIT;
          dbus_req    <= 1'b1;
          dbus_we     <= MEM_memwrite;
          dbus_addr   <= MEM_C;
          dbus_wdata  <= MEM_B;
          cnt         <= '0;
          abort       <= 1'b0;
          WB_RegWrite <= 1'b0;
        end else begin
          // an access reaching here is misaligned: dropped, no register write
          WB_RegWrite     <= MEM_RegWrite & ~access;
          WB_mem_to_reg   <= MEM_mem_to_reg;
          WB_C            <= MEM_C;
          WB_writereg_num <= MEM_writereg_num;
          misalign        <= access;
        end
        WAIT: begin
          WB_RegWrite <= 1'b0;
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            rdata_q  <= dbus_we ? rdata_q : dbus_rdata;
            state    <= DONE;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            dbus_req <= 1'b0;
            abort    <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          WB_RegWrite     <= MEM_RegWrite & ~abort;
          WB_mem_to_reg   <= MEM_mem_to_reg;
          WB_C            <= MEM_C;
          WB_D            <= (MEM_mem_to_reg & ~abort) ? rdata_q : WB_D;
          WB_writereg_num <= MEM_writereg_num;
          bus_err         <= abort;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed table-driven and sequence checks for mem_wb_stage
module tb_mem_wb_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mrw = 0, mm2r = 0, mmw = 0;
  logic [31:0] mb = 0, mc = 0, rdata = 0;
  logic [4:0]  mwn = 0;
  logic        ack = 0;
  logic        req, we, stall, wrw, wm2r, mis, berr;
  logic [31:0] addr, wdata, wc, wd;
  logic [4:0]  wwn;
  int checks = 0, failures = 0;
  int st_cnt, rq_cnt;
  logic        f_we;
  logic [31:0] f_addr, f_wdata;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .MEM_RegWrite(mrw), .MEM_mem_to_reg(mm2r), .MEM_memwrite(mmw),
    .MEM_B(mb), .MEM_C(mc), .MEM_writereg_num(mwn),
    .dbus_req(req), .dbus_we(we), .dbus_addr(addr), .dbus_wdata(wdata),
    .dbus_rdata(rdata), .dbus_ack(ack), .stall(stall),
    .WB_RegWrite(wrw), .WB_mem_to_reg(wm2r), .WB_C(wc), .WB_D(wd),
    .WB_writereg_num(wwn), .misalign(mis), .bus_err(berr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rw, m2r, mw;
    logic [31:0] b, c;
    logic [4:0] wn;
    logic e_rw, e_m2r, e_mis;
    logic [31:0] e_c;
    logic [4:0] e_wn;
  } vec_t;
  vec_t v[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic rw, m2r, mw, input logic [31:0] b, c, input logic [4:0] wn);
    mrw = rw; mm2r = m2r; mmw = mw; mb = b; mc = c; mwn = wn;
  endtask

  // steps cycles until stall drops; acks on the cycle where req has been seen ack_at times (0 = never)
  task automatic run_access(input int ack_at);
    int n;
    st_cnt = 0; rq_cnt = 0; n = 0;
    while (stall && n < 40) begin
      st_cnt++;
      if (req) begin
        rq_cnt++;
        if (rq_cnt == 1) begin f_we = we; f_addr = addr; f_wdata = wdata; end
      end
      ack = (ack_at != 0) && req && (rq_cnt == ack_at);
      edge1();
      n++;
    end
    ack = 0;
    if (n >= 40) chk("access_timeout_bound", 32'(n), 32'd0);
  endtask

  initial begin
    v[0] = '{1,0,0, 32'h0, 32'h1234, 5'd5,  1,0,0, 32'h1234, 5'd5};
    v[1] = '{1,0,0, 32'h7, 32'hFFFFFFFF, 5'd31, 1,0,0, 32'hFFFFFFFF, 5'd31};
    v[2] = '{1,1,0, 32'h0, 32'h102, 5'd7,  0,1,1, 32'h102, 5'd7};
    v[3] = '{0,0,1, 32'h99, 32'h41, 5'd2,  0,0,1, 32'h41, 5'd2};
    v[4] = '{0,0,0, 32'h0, 32'h8, 5'd1,    0,0,0, 32'h8, 5'd1};

    edge1(); edge1();
    chk("rst_req", req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_c", wc, 0);
    chk("rst_wb_rw", wrw, 0);
    @(negedge clk); rst = 0;

    foreach (v[i]) begin
      @(negedge clk);
      setin(v[i].rw, v[i].m2r, v[i].mw, v[i].b, v[i].c, v[i].wn);
      #1;
      chk($sformatf("v%0d_stall", i), stall, 0);
      edge1();
      chk($sformatf("v%0d_req", i), req, 0);
      chk($sformatf("v%0d_wb_rw", i), wrw, v[i].e_rw);
      chk($sformatf("v%0d_wb_m2r", i), wm2r, v[i].e_m2r);
      chk($sformatf("v%0d_wb_c", i), wc, v[i].e_c);
      chk($sformatf("v%0d_wb_wn", i), wwn, v[i].e_wn);
      chk($sformatf("v%0d_mis", i), mis, v[i].e_mis);
      chk($sformatf("v%0d_wb_d", i), wd, 0);
    end

    // load, ack on third WAIT cycle
    @(negedge clk);
    setin(1, 1, 0, 0, 32'h100, 5'd9);
    rdata = 32'hDEADBEEF;
    #1;
    run_access(3);
    chk("ld_stall_cycles", st_cnt, 4);
    chk("ld_req_cycles", rq_cnt, 3);
    chk("ld_we", f_we, 0);
    chk("ld_addr", f_addr, 32'h100);
    chk("ld_done_rw", wrw, 0);
    rdata = 32'h0;
    edge1();
    chk("ld_wb_d", wd, 32'hDEADBEEF);
    chk("ld_wb_m2r", wm2r, 1);
    chk("ld_wb_rw", wrw, 1);
    chk("ld_wb_wn", wwn, 9);
    setin(0, 0, 0, 0, 32'h4, 5'd0);
    edge1();
    chk("ld_rw_one_cycle", wrw, 0);

    // store, ack on first WAIT cycle
    setin(0, 0, 1, 32'hA5A5A5A5, 32'h40, 5'd0);
    #1;
    run_access(1);
    chk("st_stall_cycles", st_cnt, 2);
    chk("st_we", f_we, 1);
    chk("st_addr", f_addr, 32'h40);
    chk("st_wdata", f_wdata, 32'hA5A5A5A5);
    edge1();
    chk("st_wb_d", wd, 32'hDEADBEEF);
    chk("st_wb_rw", wrw, 0);
    chk("st_wb_c", wc, 32'h40);

    // load with no ack: times out after 4 WAIT cycles
    setin(1, 1, 0, 0, 32'h200, 5'd4);
    #1;
    run_access(0);
    chk("to_req_cycles", rq_cnt, 4);
    chk("to_stall_cycles", st_cnt, 5);
    chk("to_req_low", req, 0);
    edge1();
    chk("to_bus_err", berr, 1);
    chk("to_wb_rw", wrw, 0);
    chk("to_wb_d", wd, 32'hDEADBEEF);
    setin(1, 0, 0, 0, 32'h55, 5'd3);
    #1;
    chk("to_resume_stall", stall, 0);
    edge1();
    chk("to_err_pulse", berr, 0);
    chk("to_resume_rw", wrw, 1);
    chk("to_resume_c", wc, 32'h55);

    // reset while in WAIT, then a normal load
    setin(1, 1, 0, 0, 32'h300, 5'd6);
    edge1(); edge1();
    chk("rw_in_wait_req", req, 1);
    rst = 1;
    #1;
    chk("rw_req", req, 0);
    chk("rw_stall", stall, 0);
    chk("rw_wb_c", wc, 0);
    chk("rw_wb_d", wd, 0);
    chk("rw_wb_wn", wwn, 0);
    @(negedge clk); rst = 0;
    rdata = 32'h12345678;
    #1;
    run_access(1);
    chk("rw_ld_stall_cycles", st_cnt, 2);
    edge1();
    chk("rw_ld_wb_d", wd, 32'h12345678);
    chk("rw_ld_wb_rw", wrw, 1);
    chk("rw_ld_wb_wn", wwn, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
